// File: rtl/dcache_mem_ctrl.sv
// Miss/refill engine for d_cache: sequences one line fill or writeback at a
// time as single-word req/ack beats on the main-memory bus.
module dcache_mem_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cache_req_i,
  input  logic              cache_we_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  input  logic [DATA_W-1:0] cache_wdata_i,
  output logic [IDX_W-1:0]  cache_widx_o,
  output logic              cache_ready_o,
  output logic              cache_rvalid_o,
  output logic [IDX_W-1:0]  cache_ridx_o,
  output logic [DATA_W-1:0] cache_rdata_o,
  output logic              cache_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} CtrlState;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

  CtrlState          state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              rvalid_q, rvalid_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      rvalid_q <= 1'b0;
      ridx_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      rvalid_q <= rvalid_d;
      ridx_q   <= ridx_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    rvalid_d = 1'b0;
    ridx_d   = ridx_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cache_req_i) begin
          base_d  = cache_addr_i & LINE_MASK;
          cnt_d   = '0;
          state_d = cache_we_i ? WB : FILL;
        end
      end
      WB, FILL: begin
        if (mem_ack_i) begin
          // The counter wraps back to zero on the final beat of the line.
          cnt_d = cnt_q + IDX_W'(1);
          if (state_q == FILL) begin
            rvalid_d = 1'b1;
            ridx_d   = cnt_q;
            rdata_d  = mem_rdata_i;
          end
          if (cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cache_ready_o = 1'b0;
    cache_done_o  = 1'b0;
    cache_widx_o  = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    unique case (state_q)
      IDLE: cache_ready_o = 1'b1;
      WB: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = base_q | ADDR_W'(cnt_q);
        mem_wdata_o  = cache_wdata_i;
        cache_widx_o = cnt_q;
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q | ADDR_W'(cnt_q);
      end
      DONE:    cache_done_o = 1'b1;
      default: cache_done_o = 1'b0;
    endcase
  end

  assign cache_rvalid_o = rvalid_q;
  assign cache_ridx_o   = ridx_q;
  assign cache_rdata_o  = rdata_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Self-checking bench for dcache_mem_ctrl: a word memory with random ack
// delays, a d_cache-style shadow line, and a line-level reference model.
module tb_dcache_mem_ctrl;

  localparam int LW    = 4;
  localparam int IDX_W = 2;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } BeatT;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
    logic             withDone;
  } FillWordT;

  logic             clk = 1'b0;
  logic             rst_n_i;
  logic             cache_req_i;
  logic             cache_we_i;
  logic [31:0]      cache_addr_i;
  logic [31:0]      cache_wdata_i;
  logic [IDX_W-1:0] cache_widx_o;
  logic             cache_ready_o;
  logic             cache_rvalid_o;
  logic [IDX_W-1:0] cache_ridx_o;
  logic [31:0]      cache_rdata_o;
  logic             cache_done_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic             mem_ack_i;
  logic [31:0]      mem_rdata_i;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] shadow [LW];
  logic [31:0] memArr [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  BeatT        beatQ [$];
  FillWordT    rvalidQ [$];
  int          acceptQ [$];
  int          doneCount = 0;
  int          cycleCnt = 0;
  int          waitLeft = 0;
  int          maxWait = 0;
  logic        ackTied = 1'b0;
  logic        spuriousAck = 1'b0;
  logic        prevPending = 1'b0;
  logic [31:0] prevAddr, prevWdata;
  logic        prevWe;
  logic        ackNow;
  FillWordT    fw;

  dcache_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .cache_req_i(cache_req_i), .cache_we_i(cache_we_i),
    .cache_addr_i(cache_addr_i), .cache_wdata_i(cache_wdata_i),
    .cache_widx_o(cache_widx_o), .cache_ready_o(cache_ready_o),
    .cache_rvalid_o(cache_rvalid_o), .cache_ridx_o(cache_ridx_o),
    .cache_rdata_o(cache_rdata_o), .cache_done_o(cache_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // The cache returns writeback words combinationally by index.
  assign cache_wdata_i = shadow[cache_widx_o];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  // Memory bus responder and cache-side logger, acting mid-cycle.
  always @(negedge clk) begin
    cycleCnt++;
    if (cache_req_i && cache_ready_o) acceptQ.push_back(cycleCnt);
    if (cache_rvalid_o) begin
      fw.idx = cache_ridx_o;
      fw.data = cache_rdata_o;
      fw.withDone = cache_done_o;
      rvalidQ.push_back(fw);
    end
    if (cache_done_o) doneCount++;
    if (!mem_we_o) begin
      checkOutput("widxOutsideWb", 64'(cache_widx_o), 64'd0);
      checkOutput("wdataOutsideWb", 64'(mem_wdata_o), 64'd0);
    end
    mem_rdata_i = $urandom;
    if (mem_req_o) begin
      if (prevPending) begin
        checkOutput("stableAddr", 64'(mem_addr_o), 64'(prevAddr));
        checkOutput("stableWe", 64'(mem_we_o), 64'(prevWe));
        checkOutput("stableWdata", 64'(mem_wdata_o), 64'(prevWdata));
      end
      if (mem_we_o) checkOutput("widxMatchesAddr", 64'(cache_widx_o), 64'(mem_addr_o[IDX_W-1:0]));
      ackNow = ackTied || (waitLeft == 0);
      if (ackNow) begin
        beatQ.push_back('{addr: mem_addr_o, we: mem_we_o, wdata: mem_wdata_o});
        if (mem_we_o) memArr[mem_addr_o] = mem_wdata_o;
        else mem_rdata_i = busRead(mem_addr_o);
        waitLeft = $urandom_range(0, maxWait);
        prevPending = 1'b0;
      end else begin
        waitLeft--;
        prevPending = 1'b1;
        prevAddr = mem_addr_o;
        prevWe = mem_we_o;
        prevWdata = mem_wdata_o;
      end
    end else begin
      ackNow = ackTied || spuriousAck;
      prevPending = 1'b0;
    end
    mem_ack_i = ackNow;
  end

  // Runs one whole transaction and checks it against the line-level model.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input int maxW,
                               input logic fixedData);
    logic [31:0] base;
    int guard;
    base = addr & ~(32'(LW) - 32'd1);
    maxWait = maxW;
    for (int i = 0; i < LW; i++) shadow[i] = fixedData ? 32'hDEAD_0000 + 32'(i) : $urandom;
    guard = 0;
    while (!cache_ready_o && guard < 50) begin
      stepCycle;
      guard++;
    end
    checkOutput("readyBeforeReq", 64'(cache_ready_o), 64'd1);
    beatQ.delete();
    rvalidQ.delete();
    doneCount = 0;
    cache_we_i = we;
    cache_addr_i = addr;
    cache_req_i = 1'b1;
    stepCycle;
    cache_req_i = 1'b0;
    cache_we_i = $urandom_range(0, 1);
    cache_addr_i = $urandom;
    guard = 0;
    while (doneCount == 0 && guard < 300) begin
      stepCycle;
      guard++;
    end
    checkOutput("doneCount", 64'(doneCount), 64'd1);
    checkOutput("readyAfterDone", 64'(cache_ready_o), 64'd1);
    checkOutput("beatCount", 64'(beatQ.size()), 64'(LW));
    for (int i = 0; i < LW && i < beatQ.size(); i++) begin
      checkOutput("beatAddr", 64'(beatQ[i].addr), 64'(base + 32'(i)));
      checkOutput("beatWe", 64'(beatQ[i].we), 64'(we));
      if (we) checkOutput("beatWdata", 64'(beatQ[i].wdata), 64'(shadow[i]));
    end
    if (we) begin
      checkOutput("noRvalidOnWb", 64'(rvalidQ.size()), 64'd0);
      for (int i = 0; i < LW; i++) refMem[base + 32'(i)] = shadow[i];
    end else begin
      checkOutput("rvalidCount", 64'(rvalidQ.size()), 64'(LW));
      for (int i = 0; i < LW && i < rvalidQ.size(); i++) begin
        checkOutput("fillIdx", 64'(rvalidQ[i].idx), 64'(i));
        checkOutput("fillData", 64'(rvalidQ[i].data), 64'(refRead(base + 32'(i))));
        checkOutput("lastWordWithDone", 64'(rvalidQ[i].withDone), 64'(i == LW - 1));
      end
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    cache_req_i = 1'b0;
    cache_we_i = 1'b0;
    cache_addr_i = '0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < LW; i++) shadow[i] = '0;
    repeat (3) stepCycle;

    checkOutput("rstReady", 64'(cache_ready_o), 64'd1);
    checkOutput("rstMemReq", 64'(mem_req_o), 64'd0);
    checkOutput("rstMemWe", 64'(mem_we_o), 64'd0);
    checkOutput("rstMemAddr", 64'(mem_addr_o), 64'd0);
    checkOutput("rstRvalid", 64'(cache_rvalid_o), 64'd0);
    checkOutput("rstRidx", 64'(cache_ridx_o), 64'd0);
    checkOutput("rstRdata", 64'(cache_rdata_o), 64'd0);
    checkOutput("rstDone", 64'(cache_done_o), 64'd0);
    rst_n_i = 1'b1;
    stepCycle;

    $display("[TB] fill with ack tied high, cycle-exact");
    ackTied = 1'b1;
    cache_we_i = 1'b0;
    cache_addr_i = 32'h0000_1003;
    cache_req_i = 1'b1;
    stepCycle;
    cache_req_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checkOutput("t2MemReq", 64'(mem_req_o), 64'(c <= 4));
      checkOutput("t2MemWe", 64'(mem_we_o), 64'd0);
      if (c <= 4) checkOutput("t2MemAddr", 64'(mem_addr_o), 64'(32'h1000 + 32'(c - 1)));
      checkOutput("t2Rvalid", 64'(cache_rvalid_o), 64'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        checkOutput("t2Ridx", 64'(cache_ridx_o), 64'(c - 2));
        checkOutput("t2Rdata", 64'(cache_rdata_o), 64'((32'h1000 + 32'(c - 2)) ^ 32'hA5A5_A5A5));
      end
      checkOutput("t2Done", 64'(cache_done_o), 64'(c == 5));
      checkOutput("t2Ready", 64'(cache_ready_o), 64'(c == 6));
      stepCycle;
    end

    $display("[TB] reset in the middle of a fill");
    cache_addr_i = 32'h0000_0040;
    cache_req_i = 1'b1;
    stepCycle;
    cache_req_i = 1'b0;
    stepCycle;
    checkOutput("t1SecondBeatAddr", 64'(mem_addr_o), 64'h41);
    rst_n_i = 1'b0;
    stepCycle;
    rst_n_i = 1'b1;
    checkOutput("t1MemReq", 64'(mem_req_o), 64'd0);
    checkOutput("t1Ready", 64'(cache_ready_o), 64'd1);
    checkOutput("t1Rvalid", 64'(cache_rvalid_o), 64'd0);
    checkOutput("t1Done", 64'(cache_done_o), 64'd0);
    checkOutput("t1MemAddr", 64'(mem_addr_o), 64'd0);
    stepCycle;
    checkOutput("t1LateAckIgnored", 64'(cache_ready_o), 64'd1);
    ackTied = 1'b0;
    applyStimulus(1'b0, 32'h0000_0080, 2, 1'b0);

    $display("[TB] writeback with random wait states, then read back");
    applyStimulus(1'b1, 32'h0000_2000, 3, 1'b1);
    applyStimulus(1'b0, 32'h0000_2002, 3, 1'b0);

    $display("[TB] request held while busy");
    ackTied = 1'b1;
    acceptQ.delete();
    beatQ.delete();
    doneCount = 0;
    cache_we_i = 1'b0;
    cache_addr_i = 32'h0000_0010;
    cache_req_i = 1'b1;
    repeat (20) stepCycle;
    cache_req_i = 1'b0;
    repeat (12) stepCycle;
    ackTied = 1'b0;
    checkOutput("t4Accepts", 64'(acceptQ.size()), 64'((20 + LW + 1) / (LW + 2)));
    for (int i = 1; i < acceptQ.size(); i++)
      checkOutput("t4AcceptGap", 64'(acceptQ[i] - acceptQ[i-1]), 64'(LW + 2));
    checkOutput("t4Dones", 64'(doneCount), 64'(acceptQ.size()));
    checkOutput("t4Beats", 64'(beatQ.size()), 64'(LW * acceptQ.size()));
    for (int i = 0; i < beatQ.size(); i++)
      checkOutput("t4BeatAddr", 64'(beatQ[i].addr), 64'(32'h10 + 32'(i % LW)));

    $display("[TB] spurious ack in idle");
    rvalidQ.delete();
    spuriousAck = 1'b1;
    stepCycle;
    spuriousAck = 1'b0;
    checkOutput("t5Ready", 64'(cache_ready_o), 64'd1);
    checkOutput("t5MemReq", 64'(mem_req_o), 64'd0);
    checkOutput("t5Rvalid", 64'(rvalidQ.size()), 64'd0);
    checkOutput("t5Done", 64'(cache_done_o), 64'd0);
    applyStimulus(1'b0, 32'h0000_0500, 1, 1'b0);

    $display("[TB] random stress");
    for (int t = 0; t < 500; t++)
      applyStimulus(1'($urandom_range(0, 1)), 32'h3000 + 32'($urandom_range(0, 127)),
                    $urandom_range(0, 3), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
